// File: rtl/dm_dma_pkg.sv
// Shared types and default sizes for the dm_dma word-copy engine.
package dm_dma_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dm_dma.sv
// Word-by-word data-memory copy engine: one read cycle then one write cycle per word.
// Optional build macro DM_DMA_FILL_EN adds a pattern-fill mode that skips the read cycle.
module dm_dma
  import dm_dma_pkg::*;
#(
  parameter int ADDR_W = dm_dma_pkg::ADDR_W,
  parameter int DATA_W = dm_dma_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
`ifdef DM_DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [ADDR_W-1:0] addr,
  output logic              re,
  output logic              we,
  output logic [DATA_W-1:0] wrt_data,
  input  logic [DATA_W-1:0] rd_data
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W:0]     r_rem;
  logic [ADDR_W:0]     r_words_done;
  logic [DATA_W-1:0]   r_buf;
  logic                w_fill_req;
  logic                w_fill_act;
  logic                w_go;
  logic                w_last;

`ifdef DM_DMA_FILL_EN
  logic                r_fill;
  assign w_fill_req = fill;
  assign w_fill_act = r_fill;
`else
  assign w_fill_req = 1'b0;
  assign w_fill_act = 1'b0;
`endif

  // abort outranks start, so a simultaneous pair leaves the engine idle
  assign w_go   = start && !abort;
  assign w_last = (r_rem == {{ADDR_W{1'b0}}, 1'b1});

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if (len == '0)      w_next = ST_DONE;
          else if (w_fill_req) w_next = ST_WR;
          else                 w_next = ST_RD;
        end
      end
      ST_RD:   w_next = abort ? ST_IDLE : ST_WR;
      ST_WR: begin
        if (abort)           w_next = ST_IDLE;
        else if (w_last)     w_next = ST_DONE;
        else if (w_fill_act) w_next = ST_WR;
        else                 w_next = ST_RD;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_rem        <= '0;
      r_words_done <= '0;
      r_buf        <= '0;
`ifdef DM_DMA_FILL_EN
      r_fill       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_src        <= src;
            r_dst        <= dst;
            r_rem        <= len;
            r_words_done <= '0;
`ifdef DM_DMA_FILL_EN
            r_fill       <= fill;
            if (fill) r_buf <= pattern;
`endif
          end
        end
        // memory drives rd_data on the negedge inside RD, so it is stable here
        ST_RD: begin
          if (!abort) r_buf <= rd_data;
        end
        ST_WR: begin
          if (!abort) begin
            r_src        <= r_src + ADDR_W'(1);
            r_dst        <= r_dst + ADDR_W'(1);
            r_rem        <= r_rem - (ADDR_W+1)'(1);
            r_words_done <= r_words_done + (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign re         = (r_state == ST_RD);
  assign we         = (r_state == ST_WR);
  assign addr       = re ? r_src : (we ? r_dst : '0);
  assign wrt_data   = r_buf;
  assign words_done = r_words_done;

endmodule

// File: tb/tb_dm_dma.sv
// Self-checking bench for dm_dma: table of copy transfers plus abort/reset/busy-start sequences.
module tb_dm_dma;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
`ifdef DM_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] pattern;
`endif
  logic          busy;
  logic          done;
  logic [AW:0]   words_done;
  logic [AW-1:0] addr;
  logic          re;
  logic          we;
  logic [DW-1:0] wrt_data;
  logic [DW-1:0] rd_data = '0;

  always #5 clk = ~clk;

  dm_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef DM_DMA_FILL_EN
    .fill       (fill),
    .pattern    (pattern),
`endif
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .addr       (addr),
    .re         (re),
    .we         (we),
    .wrt_data   (wrt_data),
    .rd_data    (rd_data)
  );

  // Source memory contents are a fixed function of address: mem[a] = 0xA0 + a.
  function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
    return 32'hA0 + {19'b0, a};
  endfunction

  always @(negedge clk) rd_data <= src_word(addr);

  logic          log_clr = 1'b1;
  logic [AW-1:0] rd_log [16];
  logic [AW-1:0] wa_log [16];
  logic [DW-1:0] wd_log [16];
  int            n_rd = 0;
  int            n_wr = 0;
  int            done_cnt = 0;
  int            overlap_cnt = 0;

  always @(posedge clk) begin
    if (log_clr) begin
      n_rd     <= 0;
      n_wr     <= 0;
      done_cnt <= 0;
    end else begin
      if (re) begin
        if (n_rd < 16) rd_log[n_rd] <= addr;
        n_rd <= n_rd + 1;
      end
      if (we) begin
        if (n_wr < 16) begin
          wa_log[n_wr] <= addr;
          wd_log[n_wr] <= wrt_data;
        end
        n_wr <= n_wr + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
    if (re && we) overlap_cnt <= overlap_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_logs();
    @(negedge clk);
    log_clr = 1'b1;
    @(posedge clk);
    #1 log_clr = 1'b0;
  endtask

  // Leaves the bench at cycle 1 (#1 after the edge that samples start).
  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l);
    clr_logs();
    @(negedge clk);
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) cyc = -1;
  endtask

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW:0]   l;
    int            exp_cyc;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cyc;
    int nwr_hold;
    logic [AW-1:0] ea;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src   = '0;
    dst   = '0;
    len   = '0;
`ifdef DM_DMA_FILL_EN
    fill    = 1'b0;
    pattern = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", re, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrt_data", wrt_data, 0);
    chk("rst_words_done", words_done, 0);
    rst_n = 1'b1;

    vecs[0] = '{s: 13'd0,    d: 13'd100, l: 14'd4, exp_cyc: 9};
    vecs[1] = '{s: 13'd20,   d: 13'd30,  l: 14'd0, exp_cyc: 1};
    vecs[2] = '{s: 13'd8190, d: 13'd10,  l: 14'd3, exp_cyc: 7};
    vecs[3] = '{s: 13'd200,  d: 13'd300, l: 14'd1, exp_cyc: 3};

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].s, vecs[v].d, vecs[v].l);
      wait_done(1, cyc);
      chk($sformatf("v%0d_done_cycle", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_words_done", v), words_done, vecs[v].l);
      chk($sformatf("v%0d_n_reads", v), n_rd, vecs[v].l);
      chk($sformatf("v%0d_n_writes", v), n_wr, vecs[v].l);
      for (int i = 0; i < int'(vecs[v].l); i++) begin
        ea = vecs[v].s + AW'(i);
        chk($sformatf("v%0d_rd_addr%0d", v, i), rd_log[i], ea);
        chk($sformatf("v%0d_wr_data%0d", v, i), wd_log[i], src_word(ea));
        ea = vecs[v].d + AW'(i);
        chk($sformatf("v%0d_wr_addr%0d", v, i), wa_log[i], ea);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // Abort during the second WR of a 5-word copy
    launch(13'd400, 13'd500, 14'd5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort_in_wr", we, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_re", re, 0);
    chk("abort_we", we, 0);
    chk("abort_words_done", words_done, 1);
    nwr_hold = n_wr;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_writes_total", n_wr, 2);
    chk("abort_no_more_we", n_wr, nwr_hold);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_words_hold", words_done, 1);

    // start pulse while busy must not disturb the running copy
    launch(13'd600, 13'd700, 14'd2);
    @(posedge clk);
    #1;
    start = 1'b1;
    src   = 13'd0;
    dst   = 13'd0;
    len   = 14'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3, cyc);
    chk("busy_start_cycle", cyc, 5);
    chk("busy_start_words", words_done, 2);
    chk("busy_start_n_wr", n_wr, 2);
    chk("busy_start_wa0", wa_log[0], 700);
    chk("busy_start_wa1", wa_log[1], 701);
    chk("busy_start_ra1", rd_log[1], 601);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_idle", busy, 0);

    // abort and start together in IDLE: abort wins
    clr_logs();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    src   = 13'd5;
    dst   = 13'd6;
    len   = 14'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_start_no_rd", n_rd, 0);
    chk("abort_start_no_done", done_cnt, 0);

    // Synchronous reset in the middle of a transfer
    launch(13'd800, 13'd900, 14'd4);
    @(posedge clk);
    #1;
    chk("rst_mid_in_wr", we, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_re", re, 0);
    chk("rst_mid_we", we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_words", words_done, 0);
    chk("rst_mid_wrt_data", wrt_data, 0);
    nwr_hold = n_wr;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_more_we", n_wr, nwr_hold);
    chk("rst_mid_no_rd", n_rd, 1);

`ifdef DM_DMA_FILL_EN
    fill    = 1'b1;
    pattern = 32'hDEADBEEF;
    launch(13'd0, 13'd50, 14'd3);
    fill = 1'b0;
    wait_done(1, cyc);
    chk("fill_cycle", cyc, 4);
    chk("fill_no_re", n_rd, 0);
    chk("fill_n_wr", n_wr, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fill_wa%0d", i), wa_log[i], 50 + i);
      chk($sformatf("fill_wd%0d", i), wd_log[i], 32'hDEADBEEF);
    end
    chk("fill_words", words_done, 3);
`endif

    chk("re_we_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_dma.md
DM_DMA -- requirements
Module: dm_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, data-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data-memory word width.
REQ-003 SHALL have port clk, input, 1, the one clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, terminates an active transfer.
REQ-007 SHALL have ports src, dst, input, ADDR_W each, start word addresses; sampled with start.
REQ-008 SHALL have port len, input, ADDR_W+1, word count; sampled with start.
REQ-009 SHALL have ports busy and done, output, 1 each; done is a one-cycle pulse.
REQ-010 SHALL have port words_done, output, ADDR_W+1, count of completed writes in the current or last transfer.
REQ-011 SHALL have memory-side ports addr (output, ADDR_W), re (output, 1), we (output, 1), wrt_data (output, DATA_W) and rd_data (input, DATA_W).

Function
REQ-012 SHALL implement states IDLE, RD, WR and DONE.
REQ-013 IDLE->RD on start with len!=0; IDLE->DONE on start with len==0; RD->WR; WR->RD if words remain, else WR->DONE; DONE->IDLE.
REQ-014 In RD: re=1, we=0, addr=current source address.
REQ-015 rd_data SHALL be captured into an internal word buffer at the posedge ending RD, because the memory updates rd_data on the preceding negedge.
REQ-016 In WR: we=1, re=0, addr=current destination address, wrt_data=buffer; src and dst pointers and words_done SHALL increment at the end of the cycle.
REQ-017 re and we SHALL never be asserted in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-018 Throughput SHALL be exactly 2 cycles per word; a len=N transfer asserts done 2N+1 cycles after start is sampled.
REQ-019 Pointers SHALL wrap modulo 2^ADDR_W (8191 -> 0).
REQ-020 Copy order SHALL be strictly ascending, word by word, with no overlap correction.
REQ-021 start while busy SHALL be ignored.
REQ-022 abort in RD or WR SHALL force IDLE next cycle with re=we=0; done SHALL not pulse; words_done SHALL hold its value.
REQ-023 If abort and start arrive together in IDLE, abort SHALL win and start SHALL be ignored.
REQ-024 busy SHALL be 1 in RD, WR and DONE.

Reset
REQ-025 With rst_n low at posedge: state=IDLE; busy=done=re=we=0; addr=0; wrt_data=0; words_done=0; buffer=0.
REQ-026 Reset mid-transfer SHALL drop re and we at the same edge; no further memory access SHALL occur.

Configuration
REQ-027 Macro DM_DMA_FILL_EN defined: add input fill (1) and input pattern (DATA_W), both sampled with start; fill=1 skips RD, giving IDLE->WR->WR..., 1 word/cycle with wrt_data=pattern and done N+1 cycles after start.
REQ-028 Macro DM_DMA_FILL_EN undefined: no fill or pattern ports; copy only.

Structure
REQ-029 Shared package dm_dma_pkg SHALL hold the state enum typedef and the ADDR_W=13 and DATA_W=32 constants.
REQ-030 Single flat module, no sub-module.

Verification
REQ-031 Preload mem[0..3]=A0..A3; start src=0 dst=100 len=4 -> mem[100..103]=A0..A3, done at cycle 9, words_done=4.
REQ-032 start len=0 -> no re/we, done 1 cycle later, words_done=0.
REQ-033 src=8190 dst=10 len=3 -> reads at 8190, 8191, 0 and writes at 10, 11, 12.
REQ-034 abort in the 2nd WR of len=5 -> IDLE next cycle, words_done=1, no done, no further we.
REQ-035 Every cycle check !(re&&we); start pulses during busy cause no change in state or pointers.
REQ-036 With DM_DMA_FILL_EN: fill=1 pattern=DEADBEEF dst=50 len=3 -> mem[50..52]=DEADBEEF, re never high, done at cycle 4.
